// File: rtl/aes_cipher_core_if.sv
// rtl/aes_cipher_core_if.sv - block handshake and round-key bus for aes_cipher_core
interface aes_cipher_core_if #(
    parameter int Nr = 12
);
    logic [128*(Nr+1)-1:0] round_keys;
    logic                  keys_valid;
    logic [127:0]          plaintext;
    logic                  start;
    logic                  in_ready;
    logic                  busy;
    logic                  done;
    logic [127:0]          ciphertext;

    // master: block that supplies keys and plaintext; slave: the cipher core
    modport master (
        output round_keys, keys_valid, plaintext, start,
        input  in_ready, busy, done, ciphertext
    );

    modport slave (
        input  round_keys, keys_valid, plaintext, start,
        output in_ready, busy, done, ciphertext
    );
endinterface

// File: rtl/aes_cipher_core.sv
// rtl/aes_cipher_core.sv - iterative one-round-per-clock AES encryption core
module aes_cipher_core #(
    parameter int Nk = 6,
    parameter int Nr = 12
) (
    input  logic              clk,
    input  logic              rst,
    aes_cipher_core_if.slave  bus
);

    localparam int KW = 128 * (Nr + 1);

    generate
        if (!((Nk == 4 || Nk == 6 || Nk == 8) && (Nr == Nk + 6))) begin : g_bad_params
            $error("aes_cipher_core: illegal Nk/Nr pair");
        end
    endgenerate

    // FIPS-197 S-box, byte x stored at bits [8*(255-x) +: 8]
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_FINAL = 2'd2
    } fsm_e;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // SubBytes followed by ShiftRows; byte 4*c+r sits at row r, column c
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = sbox(s[127 - 8*(4*((c + r) % 4) + r) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c      -: 8];
            a1 = s[127 - 32*c - 8  -: 8];
            a2 = s[127 - 32*c - 16 -: 8];
            a3 = s[127 - 32*c - 24 -: 8];
            o[127 - 32*c -: 32] = {
                xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
            };
        end
        return o;
    endfunction

    fsm_e         fsm_q, fsm_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] state_q, state_d;
    logic [127:0] ct_q, ct_d;
    logic         done_q, done_d;
    logic         busy_q, busy_d;

    logic         accept;
    logic [127:0] rk_cur;
    logic [127:0] sr_out;
    logic [127:0] mc_out;

    assign accept = (fsm_q == S_IDLE) && bus.start && bus.keys_valid;

    // Shared round datapath: key select by round counter, one S-box/MixColumns bank
    always_comb begin
        rk_cur = bus.round_keys[KW - 1 - 128*int'(rnd_q) -: 128];
        sr_out = sub_shift(state_q);
        mc_out = mix_columns(sr_out);
    end

    // State register: every flop cleared asynchronously so an aborted block leaves nothing behind
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= S_IDLE;
            rnd_q   <= 4'd0;
            state_q <= '0;
            ct_q    <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            rnd_q   <= rnd_d;
            state_q <= state_d;
            ct_q    <= ct_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state: IDLE -> ROUND on accept, ROUND until round Nr-1 is applied, then one FINAL cycle
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            S_IDLE:  if (accept) fsm_d = S_ROUND;
            S_ROUND: if (rnd_q == 4'(Nr - 1)) fsm_d = S_FINAL;
            S_FINAL: fsm_d = S_IDLE;
            default: fsm_d = S_IDLE;
        endcase
    end

    // Datapath/outputs: rnd returns to 0 after FINAL so rk[0] is already selected for the next accept
    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        ct_d    = ct_q;
        done_d  = 1'b0;
        busy_d  = busy_q;
        case (fsm_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = bus.plaintext ^ rk_cur;
                    rnd_d   = 4'd1;
                    busy_d  = 1'b1;
                end
            end
            S_ROUND: begin
                state_d = mc_out ^ rk_cur;
                rnd_d   = rnd_q + 4'd1;
            end
            S_FINAL: begin
                ct_d   = sr_out ^ rk_cur;
                rnd_d  = 4'd0;
                busy_d = 1'b0;
                done_d = 1'b1;
            end
            default: begin
                rnd_d  = 4'd0;
                busy_d = 1'b0;
            end
        endcase
    end

    assign bus.in_ready   = (fsm_q == S_IDLE) && bus.keys_valid;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.ciphertext = ct_q;

endmodule

// File: tb/tb_aes_cipher_core.sv
// tb/tb_aes_cipher_core.sv - directed FIPS-197 vector bench for aes_cipher_core
module tb_aes_cipher_core;

    localparam logic [2047:0] SBOX_TAB = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    aes_cipher_core_if #(.Nr(10)) bus4 ();
    aes_cipher_core_if #(.Nr(12)) bus6 ();
    aes_cipher_core_if #(.Nr(14)) bus8 ();

    aes_cipher_core #(.Nk(4), .Nr(10)) u_core4 (.clk(clk), .rst(rst), .bus(bus4));
    aes_cipher_core #(.Nk(6), .Nr(12)) u_core6 (.clk(clk), .rst(rst), .bus(bus6));
    aes_cipher_core #(.Nk(8), .Nr(14)) u_core8 (.clk(clk), .rst(rst), .bus(bus8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] tb_sbox(input logic [7:0] x);
        return SBOX_TAB[2047 - 8*int'(x) -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {tb_sbox(w[31:24]), tb_sbox(w[23:16]), tb_sbox(w[15:8]), tb_sbox(w[7:0])};
    endfunction

    // Reference key expansion; key is left-aligned, result has round 0 at the MSBs
    function automatic logic [1919:0] expand(input logic [255:0] key, input int nk);
        logic [31:0]   w [0:59];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1919:0] s;
        int            nw;
        nw = 4 * (nk + 7);
        rc = 8'h01;
        s  = '0;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < nw; i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int i = 0; i < nw; i++) s[1919 - 32*i -: 32] = w[i];
        return s;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Start one Nk=4 block and count negedges from the accept edge to done (done cycle = Nr+1)
    task automatic run4(input string tag, input logic [127:0] pt, input logic [127:0] exp);
        int cnt;
        int bad;
        @(negedge clk);
        bus4.plaintext = pt;
        bus4.start     = 1'b1;
        @(negedge clk);
        bus4.start = 1'b0;
        cnt = 1;
        bad = 0;
        while (bus4.done !== 1'b1 && cnt < 40) begin
            if (bus4.busy !== 1'b1 || bus4.in_ready !== 1'b0) bad++;
            @(negedge clk);
            cnt++;
        end
        check({tag, "_latency"}, 128'(cnt), 128'd11);
        check({tag, "_busy_rounds"}, 128'(bad), 128'd0);
        check({tag, "_ct"}, bus4.ciphertext, exp);
        check({tag, "_busy_at_done"}, 128'(bus4.busy), 128'd0);
    endtask

    logic [1919:0] sched;
    logic [127:0]  prev_ct;
    int            cnt;
    int            extra_done;
    int            extra_busy;

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus4.round_keys = '0; bus4.keys_valid = 1'b0; bus4.plaintext = '0; bus4.start = 1'b0;
        bus6.round_keys = '0; bus6.keys_valid = 1'b0; bus6.plaintext = '0; bus6.start = 1'b0;
        bus8.round_keys = '0; bus8.keys_valid = 1'b0; bus8.plaintext = '0; bus8.start = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_busy", 128'(bus4.busy), 128'd0);
        check("rst_done", 128'(bus4.done), 128'd0);
        check("rst_ct", bus4.ciphertext, 128'd0);
        check("rst_in_ready_nokeys", 128'(bus4.in_ready), 128'd0);
        rst = 1'b0;

        sched = expand({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4);
        bus4.round_keys = sched[1919 -: 1408];
        sched = expand({192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 6);
        bus6.round_keys = sched[1919 -: 1664];
        sched = expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);
        bus8.round_keys = sched;
        bus4.keys_valid = 1'b1;
        bus6.keys_valid = 1'b1;
        bus8.keys_valid = 1'b1;
        @(negedge clk);
        check("in_ready_idle", 128'(bus4.in_ready), 128'd1);

        run4("aes128_b", 128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32);

        // AES-192
        @(negedge clk);
        bus6.plaintext = 128'h00112233445566778899aabbccddeeff;
        bus6.start     = 1'b1;
        @(negedge clk);
        bus6.start = 1'b0;
        cnt = 1;
        while (bus6.done !== 1'b1 && cnt < 40) begin @(negedge clk); cnt++; end
        check("aes192_latency", 128'(cnt), 128'd13);
        check("aes192_ct", bus6.ciphertext, 128'hdda97ca4864cdfe06eaf70a0ec0d7191);

        // AES-256
        @(negedge clk);
        bus8.plaintext = 128'h00112233445566778899aabbccddeeff;
        bus8.start     = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        cnt = 1;
        while (bus8.done !== 1'b1 && cnt < 40) begin @(negedge clk); cnt++; end
        check("aes256_latency", 128'(cnt), 128'd15);
        check("aes256_ct", bus8.ciphertext, 128'h8ea2b7ca516745bfeafc49904b496089);

        // start without keys_valid is dropped
        @(negedge clk);
        prev_ct = bus4.ciphertext;
        bus4.keys_valid = 1'b0;
        bus4.plaintext  = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
        bus4.start      = 1'b1;
        #1;
        check("nokeys_in_ready", 128'(bus4.in_ready), 128'd0);
        @(negedge clk);
        bus4.start = 1'b0;
        check("nokeys_busy", 128'(bus4.busy), 128'd0);
        check("nokeys_ct_held", bus4.ciphertext, prev_ct);
        @(negedge clk);
        bus4.keys_valid = 1'b1;
        check("nokeys_no_latch", 128'(bus4.busy), 128'd0);

        // start held high: back-to-back blocks every Nr+1 clocks
        bus4.plaintext = 128'h3243f6a8885a308d313198a2e0370734;
        bus4.start     = 1'b1;
        @(negedge clk);
        cnt = 1;
        while (bus4.done !== 1'b1 && cnt < 40) begin @(negedge clk); cnt++; end
        check("b2b_first_latency", 128'(cnt), 128'd11);
        check("b2b_first_ct", bus4.ciphertext, 128'h3925841d02dc09fbdc118597196a0b32);
        @(negedge clk);
        check("b2b_reaccept_busy", 128'(bus4.busy), 128'd1);
        cnt = 1;
        while (bus4.done !== 1'b1 && cnt < 40) begin @(negedge clk); cnt++; end
        bus4.start = 1'b0;
        check("b2b_period", 128'(cnt), 128'd11);
        check("b2b_second_ct", bus4.ciphertext, 128'h3925841d02dc09fbdc118597196a0b32);
        @(negedge clk);
        check("b2b_stop_busy", 128'(bus4.busy), 128'd0);

        // plaintext changes mid-run and a start pulse while busy are both ignored
        bus4.start = 1'b1;
        @(negedge clk);
        bus4.start     = 1'b0;
        bus4.plaintext = 128'hffffffffffffffffffffffffffffffff;
        cnt = 1;
        repeat (2) begin @(negedge clk); cnt++; end
        bus4.start = 1'b1;
        @(negedge clk);
        cnt++;
        bus4.start = 1'b0;
        while (bus4.done !== 1'b1 && cnt < 40) begin @(negedge clk); cnt++; end
        check("ign_latency", 128'(cnt), 128'd11);
        check("ign_ct", bus4.ciphertext, 128'h3925841d02dc09fbdc118597196a0b32);
        extra_done = 0;
        extra_busy = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus4.done === 1'b1) extra_done++;
            if (bus4.busy === 1'b1) extra_busy++;
        end
        check("ign_no_second_done", 128'(extra_done), 128'd0);
        check("ign_no_second_busy", 128'(extra_busy), 128'd0);

        // asynchronous reset during round 5 aborts the block
        bus4.plaintext = 128'h3243f6a8885a308d313198a2e0370734;
        bus4.start     = 1'b1;
        @(negedge clk);
        bus4.start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst_busy", 128'(bus4.busy), 128'd1);
        rst = 1'b1;
        #1;
        check("midrst_busy", 128'(bus4.busy), 128'd0);
        check("midrst_done", 128'(bus4.done), 128'd0);
        check("midrst_ct", bus4.ciphertext, 128'd0);
        @(negedge clk);
        rst = 1'b0;

        sched = expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
        bus4.round_keys = sched[1919 -: 1408];
        run4("restart", 128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_cipher_core.md
Name: aes_cipher_core

Overview:
- Iterative AES encryption datapath; sits directly downstream of the key-expansion stage and consumes its flattened round-key array.
- Accepts one 128-bit plaintext block per start handshake and performs one AES round per clock.
- Returns the 128-bit ciphertext with a one-cycle done pulse.
- Supports AES-128/192/256 through parameters, with a single shared S-box/MixColumns datapath.

Parameters:
- Nk, 6, key length in 32-bit words (4, 6 or 8).
- Nr, 12, number of rounds (10, 12 or 14); must satisfy Nr = Nk + 6.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- round_keys  in  128*(Nr+1)  flattened schedule; round key r = round_keys[128*(Nr+1)-1-128*r -: 128], so round 0 is at the MSBs
- keys_valid  in  1  high when round_keys is complete and stable
- plaintext  in  128  input block; byte 0 = bits[127:120], column-major state
- start  in  1  request; sampled only in IDLE
- in_ready  out  1  high in IDLE when keys_valid=1
- busy  out  1  high while rounds are in progress
- done  out  1  one-cycle pulse when ciphertext updates
- ciphertext  out  128  result, same byte order as plaintext

Behaviour:
- Reset (async): FSM=IDLE, round counter=0, state register=0, ciphertext=0, done=0, busy=0. Reset mid-operation aborts the block with no partial output.
- FSM states: IDLE, ROUND, FINAL.
- IDLE:
  - Accept when start && keys_valid.
  - On the accept edge: state <= plaintext ^ rk[0], rnd <= 1, go to ROUND (Nr>1 always), busy=1.
  - start with keys_valid=0 is ignored, with no latching.
- ROUND:
  - Each edge: state <= MixColumns(ShiftRows(SubBytes(state))) ^ rk[rnd]; rnd <= rnd+1.
  - When rnd == Nr-1 on that edge, go to FINAL.
- FINAL:
  - Edge: ciphertext <= ShiftRows(SubBytes(state)) ^ rk[Nr], with no MixColumns.
  - done <= 1 for exactly one cycle; busy <= 0; go to IDLE.
- Latency: accept edge to the done-high cycle is Nr+1 clocks (11/13/15 for Nk=4/6/8).
- Throughput: a start asserted in the same cycle done is high is accepted, giving back-to-back blocks every Nr+1 clocks.
- start during ROUND/FINAL is ignored, with no queueing.
- in_ready = (FSM==IDLE) && keys_valid, combinational.
- plaintext is sampled only on the accept edge; later changes have no effect.
- round_keys must stay stable while busy=1. keys_valid falling mid-operation does not abort; the result is then undefined (bench checks the protocol only).
- ciphertext holds its last value until the next FINAL edge; done=0 at all other times.
- Arithmetic:
  - SubBytes uses the FIPS-197 S-box, 16 instances, combinational.
  - MixColumns uses GF(2^8) with xtime reduction by 0x1b.
  - rnd is 4 bits wide and never exceeds Nr.
- Parameter check: an illegal Nk/Nr pair is a static error ($error at elaboration).

Test Plan:
- Nk=4/Nr=10:
  - Stimulus: schedule of key 2b7e151628aed2a6abf7158809cf4f3c; plaintext 3243f6a8885a308d313198a2e0370734; start pulse.
  - Required: done exactly 11 clocks after accept; ciphertext 3925841d02dc09fbdc118597196a0b32; busy high for rounds 1..10.
- Nk=6/Nr=12:
  - Stimulus: key 000102…1617; plaintext 00112233445566778899aabbccddeeff.
  - Required: ciphertext dda97ca4864cdfe06eaf70a0ec0d7191 after 13 clocks.
- Nk=8/Nr=14:
  - Stimulus: key 000102…1e1f; same plaintext.
  - Required: ciphertext 8ea2b7ca516745bfeafc49904b496089 after 15 clocks.
- Handshake:
  - start with keys_valid=0 → in_ready=0, no busy, ciphertext unchanged.
  - start held high throughout → blocks back-to-back, done every Nr+1 clocks.
  - plaintext changed mid-run → result unaffected.
- Reset mid-round:
  - Stimulus: assert rst at round 5 (Nk=4).
  - Required: immediately busy=0, done=0, ciphertext=0.
  - Then: a restart with the FIPS key 000102…0f / plaintext 00112233… yields 69c4e0d86a7b0430d8cdb78070b4c55a.
- Ignored start:
  - Stimulus: start pulse while busy.
  - Required: no second done, and the first result is correct.
